nco_fsk_ctrl: RTL and testbench

Continuous-phase M-ary FSK controller that drives the phase-increment and clock-enable inputs of the streaming NCO. It accepts symbols over a valid/ready handshake, holds each symbol's phase increment for a programmable number of samples, and gates the NCO clock enable. A delay line matched to the NCO pipeline marks the first NCO output sample of every symbol. It sits between the modulator's symbol source and the NCO, in the same clock domain.

---
 rtl/nco_fsk_ctrl.sv | 159 +++++++++++++++
 tb/tb_nco_fsk_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nco_fsk_ctrl.sv
// nco_fsk_ctrl
//   Continuous-phase M-ary FSK controller for the streaming NCO. Symbols are
//   accepted over a valid/ready handshake. Each symbol's phase increment is
//   looked up in a small frequency table and held for a programmable number
//   of samples. The NCO clock enable is high while symbols stream and for
//   LAT cycles afterwards, so the NCO pipeline can flush. A LAT-deep delay
//   line that advances with the NCO marks the first output sample of each
//   symbol.
//
// Ports
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   cfg_we       frequency-table write strobe
//   cfg_addr     table index to write
//   cfg_data     phase increment to store
//   sps_i        samples per symbol; sampled at accept (0 behaves as 1)
//   sym_i        symbol value (table index)
//   sym_valid    symbol present
//   sym_ready    controller can accept a symbol this cycle (combinational)
//   phi_inc_o    phase increment to the NCO
//   clken_o      clock enable to the NCO
//   sym_start_o  pulse on the first NCO output sample of each symbol
//   busy_o       high in RUN or DRAIN
module nco_fsk_ctrl #(
  parameter int APR = 32,
  parameter int BPS = 2,
  parameter int SPW = 16,
  parameter int LAT = 12   // must be >= 2
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           cfg_we,
  input  logic [BPS-1:0] cfg_addr,
  input  logic [APR-1:0] cfg_data,
  input  logic [SPW-1:0] sps_i,
  input  logic [BPS-1:0] sym_i,
  input  logic           sym_valid,
  output logic           sym_ready,
  output logic [APR-1:0] phi_inc_o,
  output logic           clken_o,
  output logic           sym_start_o,
  output logic           busy_o
);

  localparam int NTAB = 1 << BPS;
  localparam int DW   = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_next;

  logic [NTAB-1:0][APR-1:0] r_tab;
  logic [APR-1:0]           r_phi;
  logic [SPW-1:0]           r_sps;
  logic [SPW-1:0]           r_sample_cnt;
  logic [DW-1:0]            r_drain_cnt;
  logic                     r_clken;
  logic                     r_busy;
  logic                     r_first;
  logic [LAT-1:0]           r_dly;

  logic                     w_ready;
  logic                     w_accept;
  logic                     w_last;
  logic                     w_drain_end;
  logic [SPW-1:0]           w_sps_eff;

  assign w_sps_eff   = (sps_i == '0) ? SPW'(1) : sps_i;
  assign w_last      = (r_sample_cnt == (r_sps - SPW'(1)));
  assign w_drain_end = (r_drain_cnt == DW'(LAT - 1));
  assign w_accept    = sym_valid & w_ready;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_RUN;
      S_RUN:   if (w_last)   w_next = w_accept ? S_RUN : S_DRAIN;
      S_DRAIN: begin
        if (w_accept)         w_next = S_RUN;
        else if (w_drain_end) w_next = S_IDLE;
      end
      default:                w_next = S_IDLE;
    endcase
  end

  // Output logic. Ready is combinational, so a new symbol can be taken on
  // the last sample of the current one and the next symbol follows with no gap.
  always_comb begin
    w_ready = 1'b1;
    if (r_state == S_RUN) w_ready = w_last;
  end

  assign sym_ready   = w_ready;
  assign phi_inc_o   = r_phi;
  assign clken_o     = r_clken;
  assign busy_o      = r_busy;
  assign sym_start_o = r_dly[LAT-1] & r_clken;

  // Frequency table. The accept path reads the pre-write value, so a
  // same-cycle write to the same index only affects later symbols.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    r_tab <= '0;
    else if (cfg_we) r_tab[cfg_addr] <= cfg_data;
  end

  // Symbol datapath and counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_phi        <= '0;
      r_sps        <= '0;
      r_sample_cnt <= '0;
      r_drain_cnt  <= '0;
    end else begin
      if (w_accept) begin
        r_phi        <= r_tab[sym_i];
        r_sps        <= w_sps_eff;
        r_sample_cnt <= '0;
      end else if (r_state == S_RUN) begin
        r_sample_cnt <= r_sample_cnt + SPW'(1);
      end
      // drain_cnt restarts at 0 on every entry into DRAIN
      r_drain_cnt <= (r_state == S_DRAIN) ? r_drain_cnt + DW'(1) : '0;
    end
  end

  // Enable and busy are registered from the next state so that they line up
  // with the registered phase increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_clken <= 1'b0;
      r_busy  <= 1'b0;
      r_first <= 1'b0;
    end else begin
      r_clken <= (w_next != S_IDLE);
      r_busy  <= (w_next != S_IDLE);
      r_first <= w_accept;  // high on the first RUN cycle of each symbol
    end
  end

  // Start-of-symbol delay line. It advances only with the NCO, so its
  // marks stay aligned with NCO outputs across any enable gaps.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     r_dly <= '0;
    else if (r_clken) r_dly <= {r_dly[LAT-2:0], r_first};
  end

endmodule

// File: tb/tb_nco_fsk_ctrl.sv
module tb_nco_fsk_ctrl;
  localparam int APR = 32;
  localparam int BPS = 2;
  localparam int SPW = 16;
  localparam int LAT = 12;

  logic           clk = 1'b0;
  logic           reset_n = 1'b1;
  logic           cfg_we = 1'b0;
  logic [BPS-1:0] cfg_addr = '0;
  logic [APR-1:0] cfg_data = '0;
  logic [SPW-1:0] sps_i = '0;
  logic [BPS-1:0] sym_i = '0;
  logic           sym_valid = 1'b0;
  logic           sym_ready;
  logic [APR-1:0] phi_inc_o;
  logic           clken_o;
  logic           sym_start_o;
  logic           busy_o;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  logic [APR-1:0] mtab [4];

  typedef struct {
    int             cyc;
    logic [APR-1:0] phi;
  } phi_exp_t;

  phi_exp_t phi_q[$];
  int       start_q[$];

  nco_fsk_ctrl #(.APR(APR), .BPS(BPS), .SPW(SPW), .LAT(LAT)) dut (
    .clk(clk), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .sps_i(sps_i), .sym_i(sym_i), .sym_valid(sym_valid),
    .sym_ready(sym_ready), .phi_inc_o(phi_inc_o), .clken_o(clken_o),
    .sym_start_o(sym_start_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Scoreboard: expected phase increments and start pulses, keyed by cycle
  always @(negedge clk) begin
    if (reset_n) begin
      if (phi_q.size() > 0 && phi_q[0].cyc == cyc) begin
        checks++;
        if (phi_inc_o !== phi_q[0].phi) begin
          errors++;
          $display("FAIL phi_inc cyc=%0d: got %h expected %h", cyc, phi_inc_o, phi_q[0].phi);
        end
        void'(phi_q.pop_front());
      end
      if (start_q.size() > 0 && start_q[0] < cyc) begin
        checks++; errors++;
        $display("FAIL sym_start_missing: expected pulse at cyc %0d, got no pulse", start_q[0]);
        void'(start_q.pop_front());
      end
      if (sym_start_o) begin
        checks++;
        if (start_q.size() == 0) begin
          errors++;
          $display("FAIL sym_start_unexpected: pulse at cyc %0d, none expected", cyc);
        end else begin
          if (cyc != start_q[0]) begin
            errors++;
            $display("FAIL sym_start_cycle: got cyc %0d expected cyc %0d", cyc, start_q[0]);
          end
          void'(start_q.pop_front());
        end
      end
    end
  end

  task automatic wr(input logic [BPS-1:0] a, input logic [APR-1:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    mtab[a] = d;
  endtask

  // Present a symbol, wait for acceptance, and push its expectations.
  // Leaves sym_valid high so callers can stream back-to-back.
  task automatic send(input logic [BPS-1:0] s, input logic [SPW-1:0] sps,
                      input bit do_wr, input logic [BPS-1:0] wa, input logic [APR-1:0] wd,
                      output int acc, output int waited);
    phi_exp_t e;
    sym_valid = 1'b1; sym_i = s; sps_i = sps;
    if (do_wr) begin cfg_we = 1'b1; cfg_addr = wa; cfg_data = wd; end
    waited = 0;
    @(negedge clk);
    while (!sym_ready && waited < 100) begin waited++; @(negedge clk); end
    acc = cyc;
    if (!sym_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: sym_ready got %b expected 1", sym_ready);
    end else begin
      e.cyc = cyc + 1; e.phi = mtab[s];
      phi_q.push_back(e);
      start_q.push_back(cyc + 1 + LAT);
    end
    @(posedge clk); #1;
    if (do_wr) begin cfg_we = 1'b0; mtab[wa] = wd; end
  endtask

  task automatic wait_idle();
    int n;
    sym_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (busy_o && n < 200) begin n++; @(negedge clk); end
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL idle_timeout: busy_o got %b expected 0", busy_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    int t, w;
    // reset values at power-up
    #1 reset_n = 1'b0;
    #2;
    checks++;
    if ({phi_inc_o, clken_o, sym_start_o, busy_o, sym_ready} !== {32'h0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_initial: got phi=%h ce=%b ss=%b busy=%b rdy=%b expected 0 0 0 0 1",
               phi_inc_o, clken_o, sym_start_o, busy_o, sym_ready);
    end
    for (int i = 0; i < 4; i++) mtab[i] = '0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    // reset asserted while in RUN
    wr(1, 32'hDEAD_BEEF);
    send(1, 16'd8, 1'b0, 2'd0, 32'h0, t, w);
    sym_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({phi_inc_o, clken_o, sym_start_o, busy_o, sym_ready} !== {32'h0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_midrun: got phi=%h ce=%b ss=%b busy=%b rdy=%b expected 0 0 0 0 1",
               phi_inc_o, clken_o, sym_start_o, busy_o, sym_ready);
    end
    phi_q.delete();
    start_q.delete();
    for (int i = 0; i < 4; i++) mtab[i] = '0;
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({sym_ready, clken_o} !== 2'b10) begin
      errors++;
      $display("FAIL reset_release: got rdy=%b ce=%b expected rdy=1 ce=0", sym_ready, clken_o);
    end
    @(posedge clk); #1;
    // table was cleared, so symbol 1 now gives 0
    send(1, 16'd2, 1'b0, 2'd0, 32'h0, t, w);
    wait_idle();
  endtask

  task automatic test_single();
    int t, w;
    wr(1, 32'h0800_0000);
    send(1, 16'd4, 1'b0, 2'd0, 32'h0, t, w);
    sym_valid = 1'b0;
    while (cyc < t + 18) begin
      @(negedge clk);
      checks += 3;
      if (clken_o !== (cyc <= t + 16)) begin
        errors++;
        $display("FAIL single_clken cyc=t+%0d: got %b expected %b", cyc - t, clken_o, cyc <= t + 16);
      end
      if (busy_o !== (cyc <= t + 16)) begin
        errors++;
        $display("FAIL single_busy cyc=t+%0d: got %b expected %b", cyc - t, busy_o, cyc <= t + 16);
      end
      if (sym_ready !== !(cyc >= t + 1 && cyc <= t + 3)) begin
        errors++;
        $display("FAIL single_ready cyc=t+%0d: got %b expected %b", cyc - t, sym_ready,
                 !(cyc >= t + 1 && cyc <= t + 3));
      end
      if (cyc <= t + 16) begin
        checks++;
        if (phi_inc_o !== 32'h0800_0000) begin
          errors++;
          $display("FAIL single_phi_hold cyc=t+%0d: got %h expected 08000000", cyc - t, phi_inc_o);
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int t, w0, w1, w2;
    wr(0, 32'h0100_0000);
    wr(2, 32'h0200_0000);
    wr(3, 32'h0300_0000);
    send(0, 16'd3, 1'b0, 2'd0, 32'h0, t, w0);
    send(3, 16'd3, 1'b0, 2'd0, 32'h0, t, w1);
    send(2, 16'd3, 1'b0, 2'd0, 32'h0, t, w2);
    checks += 2;
    if (w1 != 2) begin
      errors++;
      $display("FAIL b2b_ready_gap1: got %0d not-ready cycles expected 2", w1);
    end
    if (w2 != 2) begin
      errors++;
      $display("FAIL b2b_ready_gap2: got %0d not-ready cycles expected 2", w2);
    end
    wait_idle();
  endtask

  task automatic test_sps0();
    int t, w0, w1;
    send(0, 16'd0, 1'b0, 2'd0, 32'h0, t, w0);
    send(3, 16'd0, 1'b0, 2'd0, 32'h0, t, w1);
    checks++;
    if (w0 != 0 || w1 != 0) begin
      errors++;
      $display("FAIL sps0_ready: got waits %0d,%0d expected 0,0", w0, w1);
    end
    wait_idle();
  endtask

  task automatic test_collision();
    int t, w;
    wr(2, 32'h0000_5678);
    send(2, 16'd2, 1'b1, 2'd2, 32'h0000_1234, t, w);
    send(2, 16'd2, 1'b0, 2'd0, 32'h0, t, w);
    wait_idle();
  endtask

  task automatic test_drain_accept();
    int t, b, w;
    wr(3, 32'h2000_0000);
    send(1, 16'd4, 1'b0, 2'd0, 32'h0, t, w);
    sym_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (clken_o !== 1'b1) begin
        errors++;
        $display("FAIL drain_clken_a cyc=t+%0d: got %b expected 1", cyc - t, clken_o);
      end
      @(posedge clk); #1;
    end
    // cycle t+9 is the 5th DRAIN cycle
    send(3, 16'd4, 1'b0, 2'd0, 32'h0, b, w);
    sym_valid = 1'b0;
    checks++;
    if (b != t + 9 || w != 0) begin
      errors++;
      $display("FAIL drain_accept_cycle: got t+%0d wait %0d expected t+9 wait 0", b - t, w);
    end
    while (cyc < b + 18) begin
      @(negedge clk);
      checks++;
      if (clken_o !== (cyc <= b + 16)) begin
        errors++;
        $display("FAIL drain_clken_b cyc=b+%0d: got %b expected %b", cyc - b, clken_o, cyc <= b + 16);
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_sps0();
    test_collision();
    test_drain_accept();
    repeat (2) @(posedge clk);
    checks++;
    if (phi_q.size() != 0 || start_q.size() != 0) begin
      errors++;
      $display("FAIL pending_expectations: got %0d phi, %0d start left expected 0",
               phi_q.size(), start_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
